// File: rtl/counter_pkg.sv
// counter_pkg: defaults shared by the upstream counter and count_capture_fifo.
//   COUNT_WIDTH    - width of the free-running count value
//   WRAP_CNT_WIDTH - width of the saturating wrap event counter
package counter_pkg;
    localparam int COUNT_WIDTH    = 4;
    localparam int WRAP_CNT_WIDTH = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO storage and pointers.
// The caller decides whether a push or pop is legal; this block just obeys.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, din    : write din at the tail
//   pop          : advance the head
//   dout         : entry at the head (meaningful only when level != 0)
//   level        : number of occupied entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage needs no reset: level gates whether any entry is visible.
    always_ff @(posedge clock) begin
        if (!reset && push)
            mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/count_capture_fifo.sv
// count_capture_fifo: samples a free-running count into a FIFO on request
// and flags when the count wraps from all-ones to zero.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   count_in     : upstream count value
//   capture      : sample count_in this cycle
//   out_ready    : consumer takes out_data this cycle
//   out_data     : oldest captured value, out_valid : head is valid
//   level        : occupied entries, overflow : sticky dropped-capture flag
//   wrap_pulse   : one-cycle wrap indication, wrap_count : saturating wraps
module count_capture_fifo
    import counter_pkg::*;
#(
    parameter int WIDTH      = COUNT_WIDTH,
    parameter int DEPTH      = 4,
    parameter int WRAP_CNT_W = WRAP_CNT_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           count_in,
    input  logic                       capture,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       wrap_pulse,
    output logic [WRAP_CNT_W-1:0]      wrap_count
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] prev_count;
    logic             full;
    logic             pop;
    logic             push;
    logic             wrap_det;

    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = capture && (!full || pop);
    assign wrap_det  = (prev_count == '1) && (count_in == '0);

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (count_in),
        .dout  (out_data),
        .level (level)
    );

    // prev_count resets to zero so a zero count right after reset is not a wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_count <= '0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_count <= count_in;
            wrap_pulse <= wrap_det;
            if (wrap_det && (wrap_count != '1))
                wrap_count <= wrap_count + 1'b1;
            if (capture && full && !pop)
                overflow <= 1'b1;
        end
    end
endmodule
